// File: rtl/vga_controller.sv
// VGA timing generator: free-running pixel/line counters with registered
// sync and blanked colour outputs aligned to the counters they accompany.
module vga_controller #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rgb,
    output logic [9:0] oCtrH,
    output logic [9:0] oCtrV,
    output logic       RED,
    output logic       GREEN,
    output logic       BLUE,
    output logic       HS,
    output logic       VS
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic [2:0] colour_q, colour_d;
    logic       visible_d;

    // Sync and colour are derived from the next counter values so that every
    // registered output lines up with the coordinates presented alongside it.
    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + 10'd1;
            end
        end

        visible_d = (h_d < H_VIS_END) && (v_d < V_VIS_END);
        hs_d      = !((h_d >= HS_START) && (h_d < HS_END));
        vs_d      = !((v_d >= VS_START) && (v_d < VS_END));
        colour_d  = visible_d ? rgb : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q      <= '0;
            v_q      <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            colour_q <= 3'b000;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            colour_q <= colour_d;
        end
    end

    assign oCtrH = h_q;
    assign oCtrV = v_q;
    assign HS    = hs_q;
    assign VS    = vs_q;
    assign RED   = colour_q[2];
    assign GREEN = colour_q[1];
    assign BLUE  = colour_q[0];

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench for vga_controller: full 800-clock lines with a shortened
// 19-line frame (12 visible, 2 front, 2 sync, 3 back) so several frames fit.
module tb_vga_controller;

    logic       clk;
    logic       rst;
    logic [2:0] rgb;
    logic [9:0] oCtrH;
    logic [9:0] oCtrV;
    logic       RED, GREEN, BLUE, HS, VS;

    int n_checks = 0;
    int n_fail   = 0;

    vga_controller #(
        .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_VISIBLE(12),  .V_FRONT(2),  .V_SYNC(2),  .V_BACK(3)
    ) dut (
        .clk(clk), .rst(rst), .rgb(rgb),
        .oCtrH(oCtrH), .oCtrV(oCtrV),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
        .HS(HS), .VS(VS)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_h"},  32'(oCtrH), 32'd0);
        check({tag, "_v"},  32'(oCtrV), 32'd0);
        check({tag, "_hs"}, 32'(HS), 32'd1);
        check({tag, "_vs"}, 32'(VS), 32'd1);
        check({tag, "_rgb"}, 32'({RED, GREEN, BLUE}), 32'd0);
    endtask

    initial begin
        int exp_h, exp_v, frame, lit, hs_low, vs_low, hs_last_fall, n_vs_fall, found;
        int vs_fall [0:3];
        logic [2:0] rgb_edge, exp_col;
        logic exp_hs, exp_vs, vis, hs_prev, vs_prev;

        // Step 1: reset held for 50 clocks
        rst = 1'b1;
        rgb = 3'b100;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset_hold");
        $display("step reset_hold: outputs checked after 50 clocks of reset");

        // Step 2: free run over two full frames plus part of a third
        exp_h = 0; exp_v = 0; frame = 0; lit = 0;
        hs_low = 0; vs_low = 0; hs_last_fall = -1; n_vs_fall = 0;
        hs_prev = 1'b1; vs_prev = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 42000; c++) begin
            @(posedge clk);
            rgb_edge = rgb;
            if (exp_h == 799) begin
                exp_h = 0;
                if (exp_v == 18) begin
                    exp_v = 0;
                    frame++;
                end else begin
                    exp_v++;
                end
            end else begin
                exp_h++;
            end
            @(negedge clk);
            vis     = (exp_h < 640) && (exp_v < 12);
            exp_hs  = !((exp_h >= 656) && (exp_h < 752));
            exp_vs  = !((exp_v >= 14) && (exp_v < 16));
            exp_col = vis ? rgb_edge : 3'b000;
            check("ctr_h", 32'(oCtrH), 32'(exp_h));
            check("ctr_v", 32'(oCtrV), 32'(exp_v));
            check("hs", 32'(HS), 32'(exp_hs));
            check("vs", 32'(VS), 32'(exp_vs));
            check("colour", 32'({RED, GREEN, BLUE}), 32'(exp_col));
            if (c == 0) begin
                check("first_edge_h", 32'(oCtrH), 32'd1);
                check("first_edge_v", 32'(oCtrV), 32'd0);
            end
            if (frame == 0 && exp_v == 10 && exp_h == 99)
                check("latency_px99", 32'({RED, GREEN, BLUE}), 32'b100);
            if (frame == 0 && exp_v == 10 && exp_h == 100)
                check("latency_px100", 32'({RED, GREEN, BLUE}), 32'b011);
            if (frame == 1 && (RED || GREEN || BLUE))
                lit++;

            if (!HS) begin
                if (hs_prev) begin
                    check("hs_fall_at", 32'(oCtrH), 32'd656);
                    if (hs_last_fall >= 0)
                        check("hs_period", 32'(c - hs_last_fall), 32'd800);
                    hs_last_fall = c;
                    hs_low = 0;
                end
                hs_low++;
            end else if (!hs_prev) begin
                check("hs_rise_at", 32'(oCtrH), 32'd752);
                check("hs_width", 32'(hs_low), 32'd96);
            end
            hs_prev = HS;

            if (!VS) begin
                if (vs_prev) begin
                    if (n_vs_fall < 4) vs_fall[n_vs_fall] = c;
                    n_vs_fall++;
                    vs_low = 0;
                end
                vs_low++;
            end else if (!vs_prev) begin
                check("vs_width", 32'(vs_low), 32'd1600);
            end
            vs_prev = VS;

            if (frame == 0 && exp_v == 10 && exp_h == 99) rgb = 3'b011;
            if (exp_v == 18 && exp_h == 799) rgb = 3'b111;
        end
        $display("step free_run: 42000 clocks checked, %0d HS-period lines, %0d VS falls", hs_last_fall >= 0, n_vs_fall);

        check("lit_pixels_frame1", 32'(lit), 32'd7680);
        check("vs_fall_count_ge3", 32'(n_vs_fall >= 3), 32'd1);
        if (n_vs_fall >= 3)
            check("two_frame_clocks", 32'(vs_fall[2] - vs_fall[0]), 32'd30400);
        $display("step frame_stats: lit=%0d vs_falls=%0d", lit, n_vs_fall);

        // Step 3: asynchronous reset mid-line at oCtrH=300
        found = 0;
        for (int c = 0; c < 1000 && !found; c++) begin
            @(negedge clk);
            if (oCtrH == 10'd300) found = 1;
        end
        check("find_h300", 32'(found), 32'd1);
        #5 rst = 1'b1;
        #1;
        check_reset_state("async_reset");
        $display("step async_reset: asserted mid-line, checked before next edge");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("async_reset_hold");
        rst = 1'b0;
        @(negedge clk);
        check("restart_h", 32'(oCtrH), 32'd1);
        check("restart_v", 32'(oCtrV), 32'd0);
        $display("step restart: counting resumed from origin");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
# vga_controller

Fixed-resolution VGA timing generator for the display path. It produces 640x480 at 60 Hz horizontal and vertical sync from a 25 MHz pixel clock, and exposes the current pixel coordinates to upstream pixel logic. It drives a 3-bit colour (one bit per channel), which is blanked outside the visible area. It sits between the pixel-colour source and the board's VGA connector.

## Interface
Parameters (defaults give 640x480@60):
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock, 25 MHz (40 ns period); all state changes on the rising edge
- rst  in  1  reset; asynchronous and active-high
- rgb  in  3  pixel colour; rgb[2]=red, rgb[1]=green, rgb[0]=blue
- oCtrH  out  10  horizontal counter, 0..799
- oCtrV  out  10  vertical counter, 0..524
- RED  out  1  red output, blanked
- GREEN  out  1  green output, blanked
- BLUE  out  1  blue output, blanked
- HS  out  1  horizontal sync, active-low
- VS  out  1  vertical sync, active-low

## Operation
- H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525).
- oCtrH increments every clock. It wraps from H_TOTAL-1 (799) to 0.
- oCtrV increments only on the clock where oCtrH wraps. It wraps from V_TOTAL-1 (524) to 0 on the same clock that oCtrH wraps.
- Visible area: oCtrH < 640 and oCtrV < 480.
- HS is 0 while H_VISIBLE+H_FRONT <= oCtrH < H_VISIBLE+H_FRONT+H_SYNC (656..751). HS is 1 otherwise.
- VS is 0 while V_VISIBLE+V_FRONT <= oCtrV < V_VISIBLE+V_FRONT+V_SYNC (490..491). VS is 1 otherwise, for the whole line including its horizontal blanking.
- RED/GREEN/BLUE = rgb[2]/rgb[1]/rgb[0] when in the visible area, else 0.
- Counters are 10 bits wide. Comparisons are unsigned. No counter value outside 0..H_TOTAL-1 or 0..V_TOTAL-1 is ever presented.
- All outputs are registers; no combinational path from rgb to outputs.

## Timing
- Reset: while rst=1, regardless of clk: oCtrH=0, oCtrV=0, HS=1, VS=1, RED=GREEN=BLUE=0.
- Reset mid-frame takes effect immediately, asynchronously. Counting resumes from (0,0).
- First rising edge after rst falls: oCtrH becomes 1, oCtrV stays 0.
- HS, VS and the colour bits are computed from the next counter values. On every cycle they correspond to the oCtrH/oCtrV presented on that same cycle.
- rgb latency: the value of rgb at rising edge N appears on RED/GREEN/BLUE after edge N, for the pixel (oCtrH, oCtrV) presented after edge N. Upstream logic must therefore present the colour for pixel P one cycle before P is displayed.
- Line period: 800 clocks (32 us). Frame period: 420 000 clocks (16.8 ms, about 59.5 Hz).
- HS low for exactly 96 consecutive clocks per line. VS low for exactly 2 lines (1600 clocks) per frame.

## Test plan
- Reset: hold rst=1 for 50 clocks with rgb=3'b100 -> oCtrH=0, oCtrV=0, HS=1, VS=1, RED=GREEN=BLUE=0. Assert rst asynchronously mid-line at oCtrH=300 -> all outputs return to reset values before the next edge.
- Horizontal sweep: release rst with rgb=3'b100 -> oCtrH counts 1..799 then 0 while oCtrV increments to 1 at the wrap. RED=1 for oCtrH 0..639 and RED=0 for 640..799. GREEN=BLUE=0 throughout.
- HS timing: HS falls exactly when oCtrH=656 and rises when oCtrH=752. Measured low width is 96 clocks and period is 800 clocks on every line.
- Vertical: run one full frame -> oCtrV reaches 524 then wraps to 0 together with oCtrH wrapping to 0. VS=0 only for oCtrV 490..491 (1600 clocks). Colour outputs are 0 for all of lines 480..524.
- Colour and latency: change rgb from 3'b100 to 3'b011 one cycle before oCtrH=100 on line 10 -> RED=0, GREEN=1, BLUE=1 starting exactly at pixel (100,10). Visible pixels per frame with any colour bit set equal 307 200 for constant rgb=3'b111.
- Frame count: run 2 frames from reset -> exactly 840 000 clocks between the first VS falling edge and the third VS falling edge. HS is never low while oCtrH < 656.
